// File: rtl/sfp_norm_row.sv
// rtl/sfp_norm_row.sv - SFP row: lane abs-sum into local/export FIFOs, then per-lane restoring divide.
// Optional SFP_SIGN_RESTORE_EN re-applies each lane's input sign to its quotient.
module sfp_norm_row #(
  parameter int COL       = 8,
  parameter int BW        = 8,
  parameter int BW_PSUM   = 2*BW+6,
  parameter int DEPTH     = 16,
  parameter int SUM_SHIFT = 7,
  parameter int SUM_W     = BW_PSUM+$clog2(COL)+1,
  parameter int DEN_W     = SUM_W-SUM_SHIFT+1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     acc_valid,
  output logic                     acc_ready,
  input  logic [COL*BW_PSUM-1:0]   sfp_in,
  input  logic                     div_valid,
  output logic                     div_ready,
  input  logic [SUM_W-1:0]         sum_in,
  output logic [COL*BW_PSUM-1:0]   sfp_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         sum_out,
  input  logic                     ext_rd,
  output logic                     ext_empty,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(BW_PSUM+1);

  typedef enum logic [1:0] {IDLE, DIVIDE, HOLD} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [BW_PSUM-1:0]    abs_w   [COL];
  logic                  sign_w  [COL];
  logic [SUM_W-1:0]      sum_w;
  logic [DEN_W-1:0]      den_w;

  logic                  pend_q;
  logic [SUM_W-1:0]      pend_sum_q;
  logic                  ovf_q;

  logic [SUM_W-1:0]      loc_mem [DEPTH];
  logic [SUM_W-1:0]      ext_mem [DEPTH];
  logic [PW-1:0]         loc_wr_q, loc_rd_q, ext_wr_q, ext_rd_q;
  logic [PW-1:0]         loc_count;
  logic                  loc_empty, loc_full, ext_full;
  logic                  acc_fire, div_fire, loc_push, ext_push, ext_pop;

  logic [BW_PSUM-1:0]    dvd_q   [COL];
  logic [DEN_W:0]        rem_q   [COL];
  logic                  sign_q  [COL];
  logic [DEN_W-1:0]      den_q;
  logic [BW_PSUM-1:0]    dvd_nx  [COL];
  logic [DEN_W:0]        rem_nx  [COL];
  logic [COL*BW_PSUM-1:0] fin_w;
  logic [COL*BW_PSUM-1:0] out_q;

  always_comb begin
    sum_w = '0;
    for (int i = 0; i < COL; i++) begin
      sign_w[i] = sfp_in[BW_PSUM*i + BW_PSUM-1];
      abs_w[i]  = sign_w[i] ? (~sfp_in[BW_PSUM*i +: BW_PSUM] + BW_PSUM'(1))
                            : sfp_in[BW_PSUM*i +: BW_PSUM];
      sum_w     = sum_w + SUM_W'(abs_w[i]);
    end
  end

  assign loc_empty = (loc_wr_q == loc_rd_q);
  assign loc_full  = (loc_wr_q[AW-1:0] == loc_rd_q[AW-1:0]) && (loc_wr_q[AW] != loc_rd_q[AW]);
  assign ext_empty = (ext_wr_q == ext_rd_q);
  assign ext_full  = (ext_wr_q[AW-1:0] == ext_rd_q[AW-1:0]) && (ext_wr_q[AW] != ext_rd_q[AW]);
  assign loc_count = loc_wr_q - loc_rd_q;

  // The in-flight push from last cycle's accept is counted so the FIFO can never overfill.
  assign acc_ready = (({1'b0, loc_count} + {{PW{1'b0}}, pend_q}) < (PW+1)'(DEPTH));
  assign div_ready = (state_q == IDLE) && !loc_empty;
  assign acc_fire  = acc_valid && acc_ready;
  assign div_fire  = div_valid && div_ready;
  assign loc_push  = pend_q && !loc_full;
  assign ext_push  = pend_q && !ext_full;
  assign ext_pop   = ext_rd && !ext_empty;

  assign sum_out   = ext_mem[ext_rd_q[AW-1:0]];
  assign den_w     = DEN_W'(loc_mem[loc_rd_q[AW-1:0]] >> SUM_SHIFT)
                   + DEN_W'(sum_in >> SUM_SHIFT) + DEN_W'(1);
  assign ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      pend_sum_q <= '0;
      ovf_q      <= 1'b0;
      loc_wr_q   <= '0;
      loc_rd_q   <= '0;
      ext_wr_q   <= '0;
      ext_rd_q   <= '0;
    end else begin
      pend_q     <= acc_fire;
      pend_sum_q <= sum_w;
      if (loc_push) loc_wr_q <= loc_wr_q + PW'(1);
      if (div_fire) loc_rd_q <= loc_rd_q + PW'(1);
      if (ext_push) ext_wr_q <= ext_wr_q + PW'(1);
      if (ext_pop)  ext_rd_q <= ext_rd_q + PW'(1);
      if ((acc_valid && !acc_ready) || (pend_q && ext_full)) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (loc_push) loc_mem[loc_wr_q[AW-1:0]] <= pend_sum_q;
    if (ext_push) ext_mem[ext_wr_q[AW-1:0]] <= pend_sum_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (div_fire) begin
          state_d = DIVIDE;
          cnt_d   = CW'(BW_PSUM);
        end
      end
      DIVIDE: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - CW'(1);
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Restoring step: quotient bits shift into the dividend register as its MSBs shift out.
  always_comb begin
    fin_w = '0;
    for (int i = 0; i < COL; i++) begin
      logic [DEN_W:0] rem_sh;
      logic           ge;
      rem_sh    = {rem_q[i][DEN_W-1:0], dvd_q[i][BW_PSUM-1]};
      ge        = (rem_sh >= {1'b0, den_q});
      rem_nx[i] = ge ? (rem_sh - {1'b0, den_q}) : rem_sh;
      dvd_nx[i] = {dvd_q[i][BW_PSUM-2:0], ge};
`ifdef SFP_SIGN_RESTORE_EN
      fin_w[BW_PSUM*i +: BW_PSUM] = sign_q[i] ? (~dvd_q[i] + BW_PSUM'(1)) : dvd_q[i];
`else
      fin_w[BW_PSUM*i +: BW_PSUM] = dvd_q[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (div_fire) begin
      den_q <= den_w;
      for (int i = 0; i < COL; i++) begin
        dvd_q[i]  <= abs_w[i];
        rem_q[i]  <= '0;
        sign_q[i] <= sign_w[i];
      end
    end else if (state_q == DIVIDE && cnt_q != '0) begin
      for (int i = 0; i < COL; i++) begin
        dvd_q[i] <= dvd_nx[i];
        rem_q[i] <= rem_nx[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                out_q <= '0;
    else if (state_q == DIVIDE && cnt_q == '0) out_q <= fin_w;
  end

  assign sfp_out   = out_q;
  assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_sfp_norm_row.sv
// tb/tb_sfp_norm_row.sv - directed self-checking bench for sfp_norm_row.
module tb_sfp_norm_row;

  localparam int COL     = 8;
  localparam int BW_PSUM = 22;
  localparam int SUM_W   = 26;
`ifdef SFP_SIGN_RESTORE_EN
  localparam bit SIGN_EN = 1'b1;
`else
  localparam bit SIGN_EN = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   acc_valid = 1'b0;
  logic                   acc_ready;
  logic [COL*BW_PSUM-1:0] sfp_in = '0;
  logic                   div_valid = 1'b0;
  logic                   div_ready;
  logic [SUM_W-1:0]       sum_in = '0;
  logic [COL*BW_PSUM-1:0] sfp_out;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [SUM_W-1:0]       sum_out;
  logic                   ext_rd = 1'b0;
  logic                   ext_empty;
  logic                   ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sfp_norm_row dut (
    .clk(clk), .reset(reset),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .sfp_in(sfp_in),
    .div_valid(div_valid), .div_ready(div_ready), .sum_in(sum_in),
    .sfp_out(sfp_out), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .ext_rd(ext_rd), .ext_empty(ext_empty), .ovf(ovf)
  );

  function automatic logic [COL*BW_PSUM-1:0] splat(input logic [BW_PSUM-1:0] v);
    logic [COL*BW_PSUM-1:0] r;
    for (int i = 0; i < COL; i++) r[BW_PSUM*i +: BW_PSUM] = v;
    return r;
  endfunction

  function automatic logic [BW_PSUM-1:0] signed_q(input logic [BW_PSUM-1:0] mag, input bit neg);
    return (SIGN_EN && neg) ? (~mag + BW_PSUM'(1)) : mag;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    acc_valid = 1'b0; div_valid = 1'b0; out_ready = 1'b0; ext_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic do_acc(input logic [COL*BW_PSUM-1:0] v);
    sfp_in = v;
    acc_valid = 1'b1;
    @(posedge clk);
    #1 acc_valid = 1'b0;
  endtask

  task automatic do_div(input logic [COL*BW_PSUM-1:0] v, input logic [SUM_W-1:0] s, output bit ok);
    ok = 1'b0;
    sfp_in = v;
    sum_in = s;
    div_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (div_ready) begin ok = 1'b1; break; end
    end
    if (ok) @(posedge clk);
    #1 div_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin cyc = k; break; end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL reset_acc_ready got=%b want=1", acc_ready); end
    checks++; if (div_ready !== 1'b0) begin errors++; $display("FAIL reset_div_ready got=%b want=0", div_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (sfp_out !== '0) begin errors++; $display("FAIL reset_sfp_out got=%h want=0", sfp_out); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    checks++; if (ext_empty !== 1'b1) begin errors++; $display("FAIL reset_ext_empty got=%b want=1", ext_empty); end
  endtask

  task automatic test_basic_latency();
    bit ok; int cyc;
    do_reset();
    do_acc(splat(22'd128));
    do_div(splat(22'd128), '0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_accept got=%b want=1", ok); end
    wait_out(cyc);
    checks++; if (cyc != 23) begin errors++; $display("FAIL basic_latency got=%0d want=23", cyc); end
    checks++; if (sfp_out !== splat(22'd14)) begin errors++; $display("FAIL basic_quot got=%h want=%h", sfp_out, splat(22'd14)); end
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got=%b want=0", out_valid); end
  endtask

  task automatic test_negative();
    bit ok; int cyc; logic [BW_PSUM-1:0] e;
    do_reset();
    do_acc(splat(BW_PSUM'(-256)));
    do_div(splat(BW_PSUM'(-256)), 26'd1024, ok);
    wait_out(cyc);
    e = signed_q(22'd10, 1'b1);
    checks++; if (cyc == 0 || sfp_out !== splat(e)) begin errors++; $display("FAIL neg_quot got=%h want=%h cyc=%0d", sfp_out, splat(e), cyc); end
    release_out();
  endtask

  task automatic test_den_one();
    bit ok; int cyc;
    logic [BW_PSUM-1:0] lane [COL];
    logic [BW_PSUM-1:0] mag  [COL];
    bit                 neg  [COL];
    logic [COL*BW_PSUM-1:0] v;
    lane = '{BW_PSUM'(-5), 22'd7, 22'd0, 22'h1FFFFF, 22'h200000, 22'd1, BW_PSUM'(-1), 22'd1000};
    mag  = '{22'd5, 22'd7, 22'd0, 22'h1FFFFF, 22'h200000, 22'd1, 22'd1, 22'd1000};
    neg  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < COL; i++) v[BW_PSUM*i +: BW_PSUM] = lane[i];
    do_reset();
    do_acc('0);
    do_div(v, '0, ok);
    wait_out(cyc);
    checks++; if (cyc != 23) begin errors++; $display("FAIL den1_latency got=%0d want=23", cyc); end
    for (int i = 0; i < COL; i++) begin
      checks++;
      if (sfp_out[BW_PSUM*i +: BW_PSUM] !== signed_q(mag[i], neg[i])) begin
        errors++;
        $display("FAIL den1_lane%0d got=%h want=%h", i, sfp_out[BW_PSUM*i +: BW_PSUM], signed_q(mag[i], neg[i]));
      end
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc;
    do_reset();
    do_acc(splat(22'd128));
    do_acc(splat(22'd64));
    do_div(splat(22'd128), '0, ok);
    wait_out(cyc);
    checks++; if (cyc == 0 || sfp_out !== splat(22'd14)) begin errors++; $display("FAIL b2b_first got=%h want=%h", sfp_out, splat(22'd14)); end
    release_out();
    do_div(splat(22'd64), '0, ok);
    wait_out(cyc);
    checks++; if (cyc == 0 || sfp_out !== splat(22'd12)) begin errors++; $display("FAIL b2b_second got=%h want=%h", sfp_out, splat(22'd12)); end
    release_out();
  endtask

  task automatic test_fifo_overflow();
    logic [COL*BW_PSUM-1:0] v;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      v = '0;
      v[BW_PSUM-1:0] = BW_PSUM'(i + 1);
      sfp_in = v;
      acc_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i == 15) begin
        checks++; if (acc_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_low got=%b want=0", acc_ready); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b want=0", ovf); end
      end
    end
    acc_valid = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", ovf); end
    repeat (2) @(posedge clk);
    #1;
    ext_rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ext_empty !== 1'b0 || sum_out !== SUM_W'(i + 1)) begin
        errors++;
        $display("FAIL ext_entry%0d got=%0d empty=%b want=%0d", i, sum_out, ext_empty, i + 1);
      end
      @(posedge clk);
      #1;
    end
    ext_rd = 1'b0;
    checks++; if (ext_empty !== 1'b1) begin errors++; $display("FAIL ext_drained got=%b want=1", ext_empty); end
  endtask

  task automatic test_div_empty();
    bit ok; int cyc;
    do_reset();
    sfp_in = splat(22'd100);
    sum_in = '0;
    div_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (div_ready !== 1'b0 || out_valid !== 1'b0 || acc_ready !== 1'b1) begin
        errors++;
        $display("FAIL empty_div got=%b%b%b want=001", div_ready, out_valid, acc_ready);
      end
    end
    @(posedge clk);
    #1 acc_valid = 1'b1;
    @(posedge clk);
    #1 acc_valid = 1'b0;
    do_div(splat(22'd100), '0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL empty_accept got=%b want=1", ok); end
    wait_out(cyc);
    checks++; if (cyc == 0 || sfp_out !== splat(22'd14)) begin errors++; $display("FAIL empty_quot got=%h want=%h", sfp_out, splat(22'd14)); end
    release_out();
  endtask

  task automatic test_backpressure();
    bit ok, bad; int cyc;
    do_reset();
    do_acc(splat(22'd300));
    do_div(splat(22'd300), '0, ok);
    wait_out(cyc);
    bad = (cyc == 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || sfp_out !== splat(22'd15)) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL hold_stable got=%h valid=%b want=%h", sfp_out, out_valid, splat(22'd15)); end
    release_out();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid_divide();
    bit ok, rose;
    do_reset();
    do_acc(splat(22'd128));
    do_div(splat(22'd128), '0, ok);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rose = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) rose = 1'b1;
    end
    checks++; if (rose) begin errors++; $display("FAIL midreset_out_valid got=1 want=0"); end
    checks++; if (ext_empty !== 1'b1) begin errors++; $display("FAIL midreset_ext_empty got=%b want=1", ext_empty); end
    checks++; if (div_ready !== 1'b0) begin errors++; $display("FAIL midreset_div_ready got=%b want=0", div_ready); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midreset_ovf got=%b want=0", ovf); end
    checks++; if (acc_ready !== 1'b1) begin errors++; $display("FAIL midreset_acc_ready got=%b want=1", acc_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_negative();
    test_den_one();
    test_back_to_back();
    test_fifo_overflow();
    test_div_empty();
    test_backpressure();
    test_reset_mid_divide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
